regfile_core: RTL and testbench
===============================

# regfile_core

Architectural register file storage for the processor: 32 registers of 32 bits with one write port and two combinational read ports. Each read port selects through a 32-input, 32-bit mux. A per-register scoreboard tracks destinations reserved by long-latency units (mult/div), so decode can stall on read-after-write hazards. The block sits between writeback (write port, reserve requests) and decode/operand fetch (read ports, busy flags).

## Interface
Parameters:
- none. Widths are fixed: 32 registers, 32-bit data, 5-bit register index.

Ports:
- clock  input  1  Single system clock. All state updates on its rising edge.
- reset  input  1  Asynchronous, active-high. Clears all registers and busy bits immediately.
- ctrl_writeEnable  input  1  Write strobe for the write port.
- ctrl_writeReg  input  5  Write destination index.
- data_writeReg  input  32  Write data.
- ctrl_readRegA  input  5  Read port A index.
- ctrl_readRegB  input  5  Read port B index.
- data_readRegA  output  32  Read port A data (combinational).
- data_readRegB  output  32  Read port B data (combinational).
- ctrl_reserve  input  1  Marks ctrl_reserveReg as pending a long-latency write.
- ctrl_reserveReg  input  5  Index being reserved.
- busy_A  output  1  Register selected by ctrl_readRegA has a pending write.
- busy_B  output  1  Register selected by ctrl_readRegB has a pending write.
- reserve_conflict  output  1  A reserve is requested on a register that is already busy (combinational).

## Operation
- Storage: regs[1..31] are 32-bit flops. regs[0] is constant 0 and has no flop.
- Write:
  - On the rising edge with ctrl_writeEnable=1 and ctrl_writeReg≠0: regs[ctrl_writeReg] ← data_writeReg.
  - A write to index 0 is ignored.
- Read:
  - data_readRegX = bypass ? data_writeReg : regs[ctrl_readRegX].
  - bypass = ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegX) & (ctrl_readRegX ≠ 0).
  - Read of index 0 always returns 0, including when a write to index 0 is in flight.
  - Port A and port B are independent. Both may read the same index.
- Scoreboard: busy[31:1] flops; busy[0] is constant 0.
  - Reserve: on the edge with ctrl_reserve=1 and ctrl_reserveReg≠0, busy[ctrl_reserveReg] ← 1.
  - Clear: on the edge with ctrl_writeEnable=1 and ctrl_writeReg≠0, busy[ctrl_writeReg] ← 0.
  - Reserve and write on the same index in the same cycle: the reserve wins, and busy stays or becomes 1. This is a new pending producer.
  - Reserve and write on different indices in the same cycle: both take effect.
- busy_X = busy[ctrl_readRegX] & ~(ctrl_writeEnable & ctrl_writeReg == ctrl_readRegX). A completing write releases the consumer in the same cycle, consistent with the data bypass.
- reserve_conflict = ctrl_reserve & busy[ctrl_reserveReg] & (ctrl_reserveReg ≠ 0). The reserve is still applied; reporting the conflict is informational, and the pipeline must stall upstream.

## Timing
- Reset (asynchronous, any time, including mid-write): all regs = 0 and all busy = 0 immediately.
  - Consequently data_readRegA/B = 0, busy_A/B = 0, and reserve_conflict = 0 for any inputs while reset is high.
  - A write or reserve coincident with the reset-release edge is ignored if reset is still high at that edge.
- Write latency:
  - 0 cycles to the read ports via bypass.
  - From the following cycle, the value is served from storage.
- Reserve latency: busy is visible on busy_X one cycle after the reserving edge, not in the reserve cycle.
- Read ports are purely combinational from the index, write inputs and state. No read latency.
- No handshake. The write port is accepted unconditionally every cycle.

## Test plan
- Reset then read all 32 indices on both ports -> every data_readReg = 0x00000000, busy_A = busy_B = 0.
- Write 0xDEADBEEF to r5. Same cycle, ctrl_readRegA = 5 -> data_readRegA = 0xDEADBEEF (bypass). Next cycle, with write disabled -> still 0xDEADBEEF from storage. Port B reading r6 -> 0.
- Write 0xFFFFFFFF to r0 while reading r0 on A -> A = 0 in that cycle and the next. Reserve r0 -> busy stays 0 and reserve_conflict = 0.
- Reserve r7, idle 3 cycles reading r7 on B -> busy_B = 0 in the reserve cycle, then 1. Write 0x12345678 to r7 -> busy_B = 0 and data_readRegB = 0x12345678 in that cycle; busy stays 0 afterward.
- Reserve r9 and write r9 (0xA5A5A5A5) in the same cycle -> next cycle busy for r9 = 1 and data = 0xA5A5A5A5. Reserve r9 again -> reserve_conflict = 1.
- Write distinct values to r1..r31, assert reset asynchronously mid-cycle during a write to r3 -> all outputs 0 immediately; after release, r3 reads 0.

Source files
------------

// File: rtl/regfile_core.sv
// Architectural register file: 32 x 32-bit, one write port, two combinational read ports,
// plus a per-register busy scoreboard for long-latency producers.
module regfile_core (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB,
  input  logic        ctrl_reserve,
  input  logic [4:0]  ctrl_reserveReg,
  output logic        busy_A,
  output logic        busy_B,
  output logic        reserve_conflict
);

  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic [31:1] busy_q, busy_d;

  // Full 32-entry views with index 0 hard-wired to zero, so the read muxes need no special case.
  logic [31:0] rd_vec [32];
  logic [31:0] busy_vec;

  logic        wr_valid;
  logic        byp_a, byp_b;
  logic        hit_a, hit_b;

  assign wr_valid = ctrl_writeEnable & (ctrl_writeReg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_writeEnable && (ctrl_writeReg == 5'(i))) begin
        regs_d[i] = data_writeReg;
        busy_d[i] = 1'b0;
      end
      // Reserve after clear: a same-index reserve is a new pending producer and wins.
      if (ctrl_reserve && (ctrl_reserveReg == 5'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_vec[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      rd_vec[i] = regs_q[i];
    end
    busy_vec = {busy_q, 1'b0};
  end

  assign hit_a = ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegA);
  assign hit_b = ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegB);
  assign byp_a = hit_a & (ctrl_readRegA != 5'd0);
  assign byp_b = hit_b & (ctrl_readRegB != 5'd0);

  // Outputs are forced low while reset is held, even if a bypassing write is presented.
  always_comb begin
    data_readRegA    = 32'd0;
    data_readRegB    = 32'd0;
    busy_A           = 1'b0;
    busy_B           = 1'b0;
    reserve_conflict = 1'b0;
    if (!reset) begin
      data_readRegA    = byp_a ? data_writeReg : rd_vec[ctrl_readRegA];
      data_readRegB    = byp_b ? data_writeReg : rd_vec[ctrl_readRegB];
      busy_A           = busy_vec[ctrl_readRegA] & ~hit_a;
      busy_B           = busy_vec[ctrl_readRegB] & ~hit_b;
      reserve_conflict = ctrl_reserve & busy_vec[ctrl_reserveReg];
    end
  end

  logic unused_wr_valid;
  assign unused_wr_valid = wr_valid;

endmodule

// File: tb/tb_regfile_core.sv
// Randomized scoreboard bench for regfile_core against an array-based reference model.
module tb_regfile_core;

  logic        clock;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_reserve;
  logic [4:0]  ctrl_reserveReg;
  logic        busy_A;
  logic        busy_B;
  logic        reserve_conflict;

  regfile_core dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_reserve     (ctrl_reserve),
    .ctrl_reserveReg  (ctrl_reserveReg),
    .busy_A           (busy_A),
    .busy_B           (busy_B),
    .reserve_conflict (reserve_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic        conf;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: plain arrays, index 0 never written.
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_regs[ctrl_writeReg] = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_reserve && ctrl_reserveReg != 0) m_busy[ctrl_reserveReg] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
    return m_regs[idx];
  endfunction

  function automatic logic m_busy_out(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (ctrl_writeEnable && ctrl_writeReg == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  task automatic push_expected(input string tag);
    exp_t e;
    e.tag = tag;
    if (reset) begin
      e.a = 0; e.b = 0; e.ba = 0; e.bb = 0; e.conf = 0;
    end else begin
      e.a    = m_read(ctrl_readRegA);
      e.b    = m_read(ctrl_readRegB);
      e.ba   = m_busy_out(ctrl_readRegA);
      e.bb   = m_busy_out(ctrl_readRegB);
      e.conf = ctrl_reserve && ctrl_reserveReg != 0 && m_busy[ctrl_reserveReg];
    end
    sb_q.push_back(e);
  endtask

  // One cycle: commit the previous cycle's inputs into the model at the edge, then drive new ones.
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic res,
                      input logic [4:0] rr, input logic rst, input string tag);
    @(posedge clock);
    model_edge();
    #1;
    reset            = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    ctrl_reserve     = res;
    ctrl_reserveReg  = rr;
    if (rst) model_clear();
    push_expected(tag);
  endtask

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h at %0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdA",  e.tag, data_readRegA, e.a);
        chk("rdB",  e.tag, data_readRegB, e.b);
        chk("busyA", e.tag, 32'(busy_A), 32'(e.ba));
        chk("busyB", e.tag, 32'(busy_B), 32'(e.bb));
        chk("conf", e.tag, 32'(reserve_conflict), 32'(e.conf));
      end
    end
  end

  initial begin
    reset = 1'b1;
    ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
    ctrl_readRegA = 0; ctrl_readRegB = 0; ctrl_reserve = 0; ctrl_reserveReg = 0;
    model_clear();
    step(1'b1, 5'd4, 32'h1111_2222, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, "in_reset");
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0, "release");

    for (int i = 0; i < 32; i++)
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 1'b0, "reset_read");

    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, "r5_bypass");
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, "r5_stored");

    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "r0_write");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "r0_after");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, "r0_reserve");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "r0_busy");

    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0, "r7_reserve");
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, "r7_wait");
    step(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, "r7_write");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, "r7_done");

    step(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, "r9_both");
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, "r9_conflict");

    for (int i = 1; i < 32; i++)
      step(1'b1, 5'(i), 32'hC000_0000 | 32'(i * 7919), 5'(i), 5'(i - 1), 1'b0, 5'd0, 1'b0,
           "fill");
    step(1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd5, 1'b1, 5'd3, 1'b1, "reset_mid");
    step(1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd5, 1'b1, 5'd3, 1'b1, "reset_edge");
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0, 5'd0, 1'b0, "post_reset");

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wr, ra, rb, rr;
      logic       narrow;
      narrow = ($urandom_range(0, 3) != 0);
      wr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rb = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step(1'($urandom), wr, $urandom, ra, rb, ($urandom_range(0, 2) == 0), rr,
           ($urandom_range(0, 199) == 0), "random");
    end

    repeat (3) @(posedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
